// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default widths/marker for the program loader
package imem_loader_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam logic [7:0] SYNC_DEF = 8'hA5;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, FIN} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake (in_data/in_valid from host, in_ready from loader)
//   master: host/UART byte source, slave: loader
interface imem_loader_if import imem_loader_pkg::*; #(parameter int DW = DW_DEF);
  logic [DW-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses SYNC/addr/len/payload/checksum frames and writes the payload to instruction memory
//   clk, rst (async, active-low); s: byte stream slave; abort: sync frame drop
//   mem_we/mem_waddr/mem_din: registered memory write port; cpu_hold: CPU held in reset while loading
//   busy: frame in progress; done: one-cycle good-frame pulse; err: sticky bad checksum
module imem_loader import imem_loader_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter logic [DW-1:0] SYNC_BYTE = DW'(SYNC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  s,
  input  logic          abort,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state, nxt;
  logic [AW-1:0] addr, count;
  logic [DW-1:0] sum;
  logic acc, last;
  // ready is forced low while reset is asserted, and during the FIN turnaround cycle
  assign s.in_ready = rst & (state != FIN);
  assign acc = s.in_valid & s.in_ready;
  // a loaded length of 0 decrements through all 2**AW values before reaching 1
  assign last = count == AW'(1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else case (state)
      IDLE: nxt = (acc && s.in_data == SYNC_BYTE) ? ADDR : IDLE;
      ADDR: nxt = acc ? LEN : ADDR;
      LEN:  nxt = acc ? DATA : LEN;
      DATA: nxt = (acc && last) ? CSUM : DATA;
      CSUM: nxt = acc ? FIN : CSUM;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_din <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      count <= '0;
      sum <= '0;
    end else begin
      mem_we <= 1'b0;
      done <= 1'b0;
      if (abort) cpu_hold <= 1'b0;
      else if (acc) case (state)
        IDLE: if (s.in_data == SYNC_BYTE) begin
          cpu_hold <= 1'b1;
          err <= 1'b0;
          sum <= '0;
        end
        ADDR: addr <= AW'(s.in_data);
        LEN: count <= AW'(s.in_data);
        DATA: begin
          mem_we <= 1'b1;
          mem_waddr <= addr;
          mem_din <= s.in_data;
          addr <= addr + 1'b1;
          sum <= sum + s.in_data;
          count <= count - 1'b1;
        end
        CSUM: if (s.in_data == sum) begin
          done <= 1'b1;
          cpu_hold <= 1'b0;
        end else err <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a frame-level write/flag model
module tb_imem_loader;
  typedef struct {logic [7:0] a; logic [7:0] d; int c;} wr_t;
  logic clk = 0, rst = 1, abort = 0;
  logic mem_we, cpu_hold, busy, done, err;
  logic [7:0] mem_waddr, mem_din;
  imem_loader_if #(.DW(8)) bus();
  imem_loader dut (.clk(clk), .rst(rst), .s(bus), .abort(abort), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err));
  always #5 clk = ~clk;
  int cyc = 0, nchk = 0, nfail = 0, gap_pct = 0, dn = 0, acc_cyc = 0;
  wr_t obs_q[$], exp_q[$];
  logic [7:0] mem [256];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back('{mem_waddr, mem_din, cyc});
      mem[mem_waddr] = mem_din;
    end
    if (done) dn++;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 3000000", $time);
    $fatal(1);
  end

  function automatic int qdiff(input int ob);
    if (obs_q.size() - ob != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[ob+i].a !== exp_q[i].a || obs_q[ob+i].d !== exp_q[i].d || obs_q[ob+i].c != exp_q[i].c)
        return i;
    return -1;
  endfunction

  // byte is accepted at the posedge that ends this task; acc_cyc is the cycle its write must appear in
  task automatic send(input logic [7:0] b);
    int n = 0;
    while ($urandom_range(99) < gap_pct) begin @(negedge clk); bus.in_valid = 0; end
    @(negedge clk); bus.in_data = b; bus.in_valid = 1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      nchk++; nfail++;
      $display("FAIL send_timeout got in_ready=%b want 1 within 50 cycles", bus.in_ready);
    end
    @(posedge clk); #1; acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk); bus.in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] st, input logic [7:0] ln, input logic [7:0] pl[$], input bit bad);
    int n = (ln == 0) ? 256 : int'(ln);
    logic [7:0] s = 0;
    exp_q.delete();
    send(8'hA5);
    nchk++;
    if (cpu_hold !== 1 || err !== 0 || busy !== 1) begin
      nfail++;
      $display("FAIL sync_flags got hold=%b err=%b busy=%b want 1 0 1", cpu_hold, err, busy);
    end
    send(st); send(ln);
    for (int i = 0; i < n; i++) begin
      send(pl[i]);
      exp_q.push_back('{st + 8'(i), pl[i], acc_cyc});
      s = s + pl[i];
    end
    send(bad ? s + 8'd1 : s);
    idle(3);
  endtask

  task automatic test_reset();
    #1 rst = 0;
    #2;
    nchk++;
    if (bus.in_ready !== 0 || mem_we !== 0 || mem_waddr !== 0 || mem_din !== 0 ||
        cpu_hold !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      nfail++;
      $display("FAIL reset_vals got rdy=%b we=%b wa=%h din=%h hold=%b busy=%b done=%b err=%b want all 0",
        bus.in_ready, mem_we, mem_waddr, mem_din, cpu_hold, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    nchk++;
    if (bus.in_ready !== 1 || busy !== 0) begin
      nfail++;
      $display("FAIL reset_release got rdy=%b busy=%b want 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_good();
    int ob = obs_q.size(), d0 = dn, q;
    run_frame(8'h10, 8'h03, '{8'h11, 8'h22, 8'h33}, 0);
    q = qdiff(ob);
    nchk++;
    if (q != -1) begin nfail++; $display("FAIL good_writes got diff=%0d nwr=%0d want -1 nwr=3", q, obs_q.size() - ob); end
    nchk++;
    if (dn - d0 != 1 || err !== 0 || cpu_hold !== 0 || busy !== 0) begin
      nfail++;
      $display("FAIL good_flags got done=%0d err=%b hold=%b busy=%b want 1 0 0 0", dn - d0, err, cpu_hold, busy);
    end
  endtask

  task automatic test_bad_csum();
    int ob = obs_q.size(), d0 = dn, q;
    run_frame(8'h10, 8'h03, '{8'h11, 8'h22, 8'h33}, 1);
    q = qdiff(ob);
    nchk++;
    if (q != -1) begin nfail++; $display("FAIL bad_writes got diff=%0d want -1", q); end
    nchk++;
    if (dn - d0 != 0 || err !== 1 || cpu_hold !== 1 || busy !== 0) begin
      nfail++;
      $display("FAIL bad_flags got done=%0d err=%b hold=%b busy=%b want 0 1 1 0", dn - d0, err, cpu_hold, busy);
    end
    d0 = dn;
    run_frame(8'h30, 8'h02, '{8'h5A, 8'hC3}, 0);
    nchk++;
    if (dn - d0 != 1 || err !== 0 || cpu_hold !== 0) begin
      nfail++;
      $display("FAIL err_clear got done=%0d err=%b hold=%b want 1 0 0", dn - d0, err, cpu_hold);
    end
  endtask

  task automatic test_wrap();
    int ob = obs_q.size(), d0 = dn, q;
    run_frame(8'hFE, 8'h03, '{8'h01, 8'h02, 8'h03}, 0);
    q = qdiff(ob);
    nchk++;
    if (q != -1 || obs_q[obs_q.size()-1].a !== 8'h00) begin
      nfail++; $display("FAIL wrap_writes got diff=%0d last_addr=%h want -1 00", q, obs_q[obs_q.size()-1].a);
    end
    nchk++;
    if (dn - d0 != 1 || err !== 0) begin nfail++; $display("FAIL wrap_done got done=%0d err=%b want 1 0", dn - d0, err); end
  endtask

  task automatic test_garbage_toggle();
    int ob = obs_q.size(), d0 = dn, q;
    gap_pct = 50;
    send(8'h00); send(8'hFF); send(8'h12);
    idle(2);
    nchk++;
    if (obs_q.size() != ob || busy !== 0 || cpu_hold !== 0) begin
      nfail++;
      $display("FAIL garbage got nwr=%0d busy=%b hold=%b want 0 0 0", obs_q.size() - ob, busy, cpu_hold);
    end
    run_frame(8'h80, 8'h04, '{8'hA5, 8'h00, 8'hFF, 8'h7E}, 0);
    gap_pct = 0;
    q = qdiff(ob);
    nchk++;
    if (q != -1 || dn - d0 != 1) begin nfail++; $display("FAIL toggle_frame got diff=%0d done=%0d want -1 1", q, dn - d0); end
  endtask

  task automatic test_abort();
    int ob, q;
    run_frame(8'h50, 8'h01, '{8'h99}, 1);
    @(negedge clk); abort = 1;
    @(posedge clk); #1;
    nchk++;
    if (err !== 1 || cpu_hold !== 0 || busy !== 0) begin
      nfail++; $display("FAIL abort_idle got err=%b hold=%b busy=%b want 1 0 0", err, cpu_hold, busy);
    end
    @(negedge clk); abort = 0;
    ob = obs_q.size();
    exp_q.delete();
    send(8'hA5); send(8'h40); send(8'h05);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] p = 8'($urandom);
      send(p);
      exp_q.push_back('{8'h40 + 8'(k), p, acc_cyc});
    end
    @(negedge clk); abort = 1; bus.in_data = 8'hEE; bus.in_valid = 1;
    @(posedge clk); #1;
    nchk++;
    if (busy !== 0 || cpu_hold !== 0 || err !== 0) begin
      nfail++; $display("FAIL abort_data got busy=%b hold=%b err=%b want 0 0 0", busy, cpu_hold, err);
    end
    @(negedge clk); abort = 0; bus.in_valid = 0;
    idle(2);
    q = qdiff(ob);
    nchk++;
    if (q != -1) begin nfail++; $display("FAIL abort_writes got diff=%0d nwr=%0d want -1 nwr=2", q, obs_q.size() - ob); end
    send(8'hA5); send(8'h20); send(8'h08);
    send(8'h01); send(8'h02); send(8'h03);
    @(negedge clk); #1 rst = 0; bus.in_valid = 0;
    #1;
    nchk++;
    if (bus.in_ready !== 0 || mem_we !== 0 || mem_waddr !== 0 || mem_din !== 0 ||
        cpu_hold !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      nfail++;
      $display("FAIL midreset got rdy=%b we=%b wa=%h din=%h hold=%b busy=%b done=%b err=%b want all 0",
        bus.in_ready, mem_we, mem_waddr, mem_din, cpu_hold, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1;
    idle(1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int ob = obs_q.size(), d0 = dn, q;
      logic [7:0] st = 8'($urandom), ln = 8'($urandom_range(24, 1));
      logic [7:0] pl[$];
      bit bad = ($urandom_range(2) == 0);
      for (int i = 0; i < ln; i++) pl.push_back(8'($urandom));
      gap_pct = $urandom_range(60);
      run_frame(st, ln, pl, bad);
      q = qdiff(ob);
      nchk++;
      if (q != -1) begin nfail++; $display("FAIL rand%0d_writes got diff=%0d want -1", f, q); end
      nchk++;
      if (dn - d0 != (bad ? 0 : 1) || err !== bad || cpu_hold !== bad) begin
        nfail++;
        $display("FAIL rand%0d_flags got done=%0d err=%b hold=%b want %0d %b %b", f, dn - d0, err, cpu_hold, !bad, bad, bad);
      end
    end
    gap_pct = 0;
  endtask

  task automatic test_full();
    int ob = obs_q.size(), d0 = dn, q, nbad = 0;
    logic [7:0] pl[$];
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_frame(8'h00, 8'h00, pl, 0);
    q = qdiff(ob);
    nchk++;
    if (q != -1) begin nfail++; $display("FAIL full_writes got diff=%0d nwr=%0d want -1 nwr=256", q, obs_q.size() - ob); end
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) nbad++;
    nchk++;
    if (nbad != 0) begin nfail++; $display("FAIL full_mem got %0d wrong locations want 0", nbad); end
    nchk++;
    if (dn - d0 != 1 || err !== 0 || cpu_hold !== 0) begin
      nfail++; $display("FAIL full_done got done=%0d err=%b hold=%b want 1 0 0", dn - d0, err, cpu_hold);
    end
  endtask

  initial begin
    bus.in_data = 0;
    bus.in_valid = 0;
    test_reset();
    test_good();
    test_bad_csum();
    test_wrap();
    test_garbage_toggle();
    test_abort();
    test_random();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
